// File: rtl/xulie_pkg.sv
// xulie_pkg: shared definitions for the xulie serial pattern transmitter.
//   tx_state_e  one-hot transmitter states TX_IDLE, TX_PRE, TX_DATA, TX_GAP
//   SYNC_0110   default 4-bit sync preamble
//   LINE_IDLE   level of the serial line when nothing is being sent
package xulie_pkg;

    typedef enum logic [3:0] {
        TX_IDLE = 4'b0001,
        TX_PRE  = 4'b0010,
        TX_DATA = 4'b0100,
        TX_GAP  = 4'b1000
    } tx_state_e;

    localparam logic [3:0] SYNC_0110 = 4'b0110;
    localparam logic       LINE_IDLE = 1'b1;

endpackage

// File: rtl/xulie_pattern_tx_if.sv
// xulie_pattern_tx_if: load handshake and serial output of the pattern
// transmitter.
//   Load    master -> slave  load request
//   Data    master -> slave  word to transmit (WIDTH bits)
//   Repeat  master -> slave  extra frames to send (total = Repeat+1)
//   Ready   slave -> master  transmitter idle and accepting a Load
//   Busy    slave -> master  preamble, data or gap in progress
//   Dout    slave -> master  registered serial line, MSB first, idles high
//   Done    slave -> master  one-cycle pulse after the final frame
//
// Handshake: a transfer happens on a rising Clk edge where Load=1 and Ready=1.
// Data and Repeat are captured only on that edge; Load while Ready=0 is
// ignored and does not disturb the frame in progress.
interface xulie_pattern_tx_if #(
    parameter int WIDTH = 8
);
    logic             Load;
    logic [WIDTH-1:0] Data;
    logic [3:0]       Repeat;
    logic             Ready;
    logic             Busy;
    logic             Dout;
    logic             Done;

    modport master (output Load, Data, Repeat, input Ready, Busy, Dout, Done);
    modport slave  (input Load, Data, Repeat, output Ready, Busy, Dout, Done);
endinterface

// File: rtl/xulie_shift_reg.sv
// xulie_shift_reg: parallel-load, MSB-first shift register.
//   Clk    rising-edge clock
//   Reset  asynchronous active-high reset (clears the register)
//   load   parallel load of din (has priority over shift)
//   shift  shift one place toward the MSB, filling with the idle level
//   din    parallel load value
//   msb    current most-significant bit
module xulie_shift_reg
    import xulie_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);
    logic [WIDTH-1:0] sr;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= {sr[WIDTH-2:0], LINE_IDLE};
        end
    end

    assign msb = sr[WIDTH-1];
endmodule

// File: rtl/xulie_pattern_tx.sv
// xulie_pattern_tx: serial pattern transmitter. A word accepted through the
// Load/Ready handshake is sent MSB-first on Dout, one bit per Clk, repeated
// Repeat+1 times with GAP idle cycles between frames.
//   Clk        rising-edge clock
//   Reset      asynchronous active-high reset
//   bus        xulie_pattern_tx_if slave (Load/Data/Repeat in,
//              Ready/Busy/Dout/Done out)
//   dbg_state  current FSM state
// Build option: define XULIE_PREAMBLE_EN to prefix every frame with the
// 4-bit PREAMBLE; without it frames carry data bits only.
module xulie_pattern_tx
    import xulie_pkg::*;
#(
    parameter int         WIDTH    = 8,
    parameter int         GAP      = 2,
    parameter logic [3:0] PREAMBLE = SYNC_0110
) (
    input  logic               Clk,
    input  logic               Reset,
    xulie_pattern_tx_if.slave  bus,
    output tx_state_e          dbg_state
);
    localparam int BW = $clog2(WIDTH);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [GW-1:0] LAST_GAP = GW'(GAP - 1);

    tx_state_e        state, state_d;
    logic [BW-1:0]    bit_cnt, bit_d;
    logic [GW-1:0]    gap_cnt, gap_d;
    logic [3:0]       frame_cnt, frame_d;
    logic [WIDTH-1:0] word_q, next_word, sr_din;
    logic             dout_q, dout_d, done_q, done_d;
    logic             capture, start, sr_load, sr_shift, sr_msb;
`ifdef XULIE_PREAMBLE_EN
    logic [1:0]       pre_cnt, pre_d;
`else
    logic             unused_preamble;
    assign unused_preamble = ^PREAMBLE;
`endif

    xulie_shift_reg #(.WIDTH(WIDTH)) u_shift (
        .Clk   (Clk),
        .Reset (Reset),
        .load  (sr_load),
        .shift (sr_shift),
        .din   (sr_din),
        .msb   (sr_msb)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= TX_IDLE;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            frame_cnt <= '0;
            word_q    <= '0;
            dout_q    <= LINE_IDLE;
            done_q    <= 1'b0;
`ifdef XULIE_PREAMBLE_EN
            pre_cnt   <= '0;
`endif
        end else begin
            state     <= state_d;
            bit_cnt   <= bit_d;
            gap_cnt   <= gap_d;
            frame_cnt <= frame_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
            if (capture) begin
                word_q <= bus.Data;
            end
`ifdef XULIE_PREAMBLE_EN
            pre_cnt   <= pre_d;
`endif
        end
    end

    // dout_d is the bit that Dout will show in the cycle after this edge,
    // so every transition also chooses the first bit of the state it enters.
    always_comb begin
        state_d   = state;
        bit_d     = bit_cnt;
        gap_d     = gap_cnt;
        frame_d   = frame_cnt;
        dout_d    = LINE_IDLE;
        done_d    = 1'b0;
        capture   = 1'b0;
        start     = 1'b0;
        sr_load   = 1'b0;
        sr_shift  = 1'b0;
        sr_din    = word_q;
        next_word = word_q;
`ifdef XULIE_PREAMBLE_EN
        pre_d     = pre_cnt;
`endif
        case (state)
            TX_IDLE: begin
                if (bus.Load) begin
                    capture = 1'b1;
                    frame_d = bus.Repeat;
                    start   = 1'b1;
                end
            end
`ifdef XULIE_PREAMBLE_EN
            TX_PRE: begin
                if (pre_cnt == 2'd3) begin
                    state_d  = TX_DATA;
                    bit_d    = '0;
                    dout_d   = sr_msb;
                    sr_shift = 1'b1;
                end else begin
                    pre_d  = pre_cnt + 1'b1;
                    // bit index 3-k of a 2-bit count k is simply ~k
                    dout_d = PREAMBLE[~pre_d];
                end
            end
`endif
            TX_DATA: begin
                if (bit_cnt == LAST_BIT) begin
                    if (frame_cnt == 4'd0) begin
                        state_d = TX_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        frame_d = frame_cnt - 1'b1;
                        if (GAP == 0) begin
                            start = 1'b1;
                        end else begin
                            state_d = TX_GAP;
                            gap_d   = '0;
                        end
                    end
                end else begin
                    bit_d    = bit_cnt + 1'b1;
                    dout_d   = sr_msb;
                    sr_shift = 1'b1;
                end
            end
            TX_GAP: begin
                if (gap_cnt == LAST_GAP) begin
                    start = 1'b1;
                end else begin
                    gap_d = gap_cnt + 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase

        // Frame start: a fresh Load uses the bus word, a repeat reuses the
        // captured copy so later changes on Data cannot leak in.
        if (start) begin
            next_word = capture ? bus.Data : word_q;
            sr_load   = 1'b1;
`ifdef XULIE_PREAMBLE_EN
            state_d   = TX_PRE;
            pre_d     = '0;
            dout_d    = PREAMBLE[3];
            sr_din    = next_word;
`else
            // The MSB goes straight to Dout, so load the word pre-shifted.
            state_d   = TX_DATA;
            bit_d     = '0;
            dout_d    = next_word[WIDTH-1];
            sr_din    = {next_word[WIDTH-2:0], LINE_IDLE};
`endif
        end
    end

    assign bus.Ready = (state == TX_IDLE);
    assign bus.Busy  = (state != TX_IDLE);
    assign bus.Dout  = dout_q;
    assign bus.Done  = done_q;
    assign dbg_state = state;
endmodule

// File: tb/tb_xulie_pattern_tx.sv
// tb_xulie_pattern_tx: self-checking bench for xulie_pattern_tx (WIDTH=8,
// GAP=2). Honours XULIE_PREAMBLE_EN the same way as the design.
module tb_xulie_pattern_tx;
    import xulie_pkg::*;

    localparam int WIDTH = 8;
    localparam int GAP   = 2;
`ifdef XULIE_PREAMBLE_EN
    localparam bit PRE_ON = 1'b1;
`else
    localparam bit PRE_ON = 1'b0;
`endif
    localparam int F = WIDTH + (PRE_ON ? 4 : 0);
    localparam logic [3:0] V_IDLE = 4'b1001;  // {Ready,Busy,Done,Dout}
    localparam logic [3:0] V_DONE = 4'b1011;
    localparam logic [3:0] V_GAP  = 4'b0101;

    // clock / reset
    logic Clk   = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    xulie_pattern_tx_if #(.WIDTH(WIDTH)) bus ();
    tx_state_e dbg_state;

    xulie_pattern_tx #(.WIDTH(WIDTH), .GAP(GAP), .PREAMBLE(SYNC_0110)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int checks   = 0;
    int failures = 0;
    logic [3:0] exp_q[$];
    int det_cnt = 0;
    logic [3:0] win = 4'hF;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] obs();
        return {bus.Ready, bus.Busy, bus.Done, bus.Dout};
    endfunction

    // expected per-cycle outputs for one accepted Load, starting at cycle n+1
    task automatic push_frames(input logic [7:0] d, input logic [3:0] rep);
        logic [3:0] pre;
        pre = 4'b0110;
        for (int f = 0; f <= int'(rep); f++) begin
            if (PRE_ON) begin
                for (int i = 3; i >= 0; i--) exp_q.push_back({3'b010, pre[i]});
            end
            for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back({3'b010, d[i]});
            if (f < int'(rep)) begin
                for (int g = 0; g < GAP; g++) exp_q.push_back(V_GAP);
            end
        end
        exp_q.push_back(V_DONE);
    endtask

    // scoreboard: one comparison per cycle; an empty queue means idle line.
    // A 4-bit window doubles as the 0110 sequence detector for loopback.
    always @(negedge Clk) begin
        logic [3:0] exp_v;
        if (!Reset) begin
            win = {win[2:0], bus.Dout};
            if (win == 4'b0110) det_cnt++;
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : V_IDLE;
            check("cycle", obs(), exp_v);
        end
    end

    // mode 0: return in the Done cycle; 1: also poke Load/Data=00 at n+5;
    // 2: return right after acceptance
    task automatic send(input logic [7:0] d, input logic [3:0] rep, input int mode);
        bit ok;
        int len;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge Clk);
            if (bus.Ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("ready_wait", 32'(ok), 1);
        if (!ok) return;
        bus.Load   = 1'b1;
        bus.Data   = d;
        bus.Repeat = rep;
        @(posedge Clk);
        #1;
        bus.Load   = 1'b0;
        bus.Data   = ~d;
        bus.Repeat = 4'd0;
        push_frames(d, rep);
        len = (int'(rep) + 1) * F + int'(rep) * GAP;
        if (mode == 2) return;
        for (int c = 1; c <= len; c++) begin
            if (mode == 1 && c == 5) begin
                @(negedge Clk);
                bus.Load   = 1'b1;
                bus.Data   = 8'h00;
                bus.Repeat = 4'd3;
                @(posedge Clk);
                #1;
                bus.Load   = 1'b0;
            end else begin
                @(posedge Clk);
            end
        end
    endtask

    initial begin
        int d0;
        bus.Load   = 1'b0;
        bus.Data   = '0;
        bus.Repeat = 4'd0;
        Reset      = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_dout",  32'(bus.Dout),  1);
        check("rst_ready", 32'(bus.Ready), 1);
        check("rst_busy",  32'(bus.Busy),  0);
        check("rst_done",  32'(bus.Done),  0);
        check("rst_state", 32'(dbg_state), 32'(TX_IDLE));
        @(negedge Clk);
        Reset = 1'b0;

        // single frame, then repeated frames with gaps
        send(8'hA5, 4'd0, 0);
        repeat (3) @(posedge Clk);
        send(8'h3C, 4'd2, 0);
        repeat (2) @(posedge Clk);

        // loopback into the 0110 detector: one hit per frame with preamble
        d0 = det_cnt;
        send(8'hFF, 4'd1, 0);
        repeat (3) @(posedge Clk);
        check("det_count", 32'(det_cnt - d0), PRE_ON ? 2 : 0);

        // Load while busy is ignored; back-to-back Load in the Done cycle
        send(8'hA5, 4'd0, 1);
        send(8'h96, 4'd0, 0);
        repeat (2) @(posedge Clk);

        // maximum repeat count: 16 frames
        send(8'($urandom_range(0, 255)), 4'd15, 0);

        // random words and repeat counts
        for (int k = 0; k < 5; k++) begin
            send(8'($urandom_range(0, 255)), 4'($urandom_range(0, 3)), 0);
            repeat ($urandom_range(0, 2)) @(posedge Clk);
        end

        // reset mid-frame at cycle n+7: outputs idle at once, no Done
        send(8'hA5, 4'd0, 2);
        repeat (6) @(posedge Clk);
        #2;
        exp_q.delete();
        Reset = 1'b1;
        #1;
        check("midrst_dout",  32'(bus.Dout),  1);
        check("midrst_busy",  32'(bus.Busy),  0);
        check("midrst_ready", 32'(bus.Ready), 1);
        check("midrst_done",  32'(bus.Done),  0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (2) @(posedge Clk);
        send(8'h81, 4'd0, 0);

        repeat (4) @(posedge Clk);
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/xulie_pattern_tx.md
# xulie_pattern_tx

Serial pattern transmitter: accepts a parallel word through a load/ready handshake and emits it MSB-first on a single-bit line, one bit per Clk. An optional fixed 4-bit sync preamble (0110) precedes each frame, and a frame can be repeated with idle gaps. It drives the serial stimulus consumed by the team's 0110/1110 sequence-detector blocks, and serves as their self-check source in loopback benches.

## Interface
- WIDTH, 8: data word width in bits; legal range 2..32.
- GAP, 2: idle cycles (Dout=1) between repeated frames; 0 means back-to-back frames.
- PREAMBLE, 4'b0110: sync pattern sent MSB-first before the data. Active only with PREAMBLE_EN.

- Reset  input  1  asynchronous, active-high; clock Clk.
- Clk  input  1  rising-edge clock.
- Load  input  1  load request; sampled only while Ready=1.
- Data  input  WIDTH  word to transmit; captured on an accepted Load.
- Repeat  input  4  extra frames; total frames = Repeat+1; captured with Data.
- Ready  output  1  high in IDLE; accepting a Load.
- Busy  output  1  high while any frame, preamble or gap is in progress.
- Dout  output  1  serial data, registered; idle level 1.
- Done  output  1  one-cycle pulse after the last bit of the final frame.

## Operation
- One-hot FSM with states IDLE, PRE, DATA and GAP.
- **IDLE**
  - Outputs: Dout=1, Ready=1, Busy=0.
  - Load=1 at an edge captures Data into the shift register, captures Repeat into the frame counter, and moves to PRE (or to DATA without PREAMBLE_EN).
- **PRE**
  - Drives PREAMBLE[3] down to PREAMBLE[0], one bit per cycle, for 4 cycles.
  - Then moves to DATA.
- **DATA**
  - Drives Data[WIDTH-1] down to Data[0] for WIDTH cycles.
  - The bit counter counts from 0 to WIDTH-1.
  - After the last bit:
    - If the frame counter is 0, go to IDLE and pulse Done.
    - Otherwise decrement the frame counter, reload the captured word, and go to GAP (or directly to PRE/DATA when GAP=0).
- **GAP**
  - Dout=1 for GAP cycles, then moves to PRE (or to DATA without PREAMBLE_EN).
- The captured word is held in a separate register, so repeated frames resend the same word.
- Load while Ready=0 is ignored and does not affect the frame in progress.
- Data and Repeat changing after capture have no effect.
- Done and Ready are both high in the first IDLE cycle. A Load in that cycle is accepted, and the new frame starts the next cycle with no extra idle bit.
- Illegal (non-one-hot) state recovers to IDLE on the next edge, with Dout=1.

## Timing
- **Reset values:** Dout=1, Ready=1, Busy=0, Done=0; state IDLE; all counters 0.
- **Reset mid-frame:** outputs go to their reset values immediately (asynchronously) and the frame is abandoned; no Done pulse.
- **Latency:** a Load accepted at edge n puts the first serial bit on Dout during cycle n+1.
- **Frame length:** F = WIDTH+4 cycles with PREAMBLE_EN, WIDTH without.
- **Final Done pulse:** cycle n+1+(Repeat+1)·F+Repeat·GAP.
- Busy is high from cycle n+1 through the last data bit, including gaps.
- Bit counter width is clog2(WIDTH); the counter never wraps within a frame.
- Frame counter is 4 bits and decrements without wrap.
- Repeat=15 gives 16 frames.

## Configuration
- Macro: XULIE_PREAMBLE_EN.
- **Defined:**
  - PRE state is present.
  - Each frame starts with the PREAMBLE bits (default 0,1,1,0).
  - F = WIDTH+4.
- **Undefined:**
  - PRE state and its counter logic are compiled out.
  - Frames contain only data bits.
  - F = WIDTH.
  - The PREAMBLE parameter is unused.

## Structure
- **Shared package xulie_pkg:**
  - One-hot state localparams: TX_IDLE, TX_PRE, TX_DATA, TX_GAP.
  - Default preamble constant SYNC_0110 = 4'b0110.
  - Idle-level constant LINE_IDLE = 1'b1.
- **Sub-module xulie_shift_reg:**
  - Parameterised WIDTH.
  - Parallel load, MSB-first shift-out on an enable.
  - Asynchronous active-high Reset.
  - Instantiated once for the data word.
- Preamble bits are indexed from the constant; no second shift register.

## Test plan
- **Single frame with preamble:** PREAMBLE_EN, WIDTH=8, Data=8'hA5, Repeat=0, Load at edge n.
  - Dout in cycles n+1..n+12 = 0,1,1,0,1,0,1,0,0,1,0,1.
  - Done=1 only in cycle n+13.
- **Repeated frames with gaps:** Repeat=2, GAP=2, Data=8'h3C.
  - Three identical 12-bit frames separated by two 1s.
  - Busy high throughout; single Done in cycle n+41.
- **Loopback to detector:** Dout fed into the 0110 Moore detector with Data=8'hFF.
  - Detector output goes high exactly once per frame, 4 cycles after the frame's first preamble bit appears on Dout.
- **Load while busy:** Load=1 with Data=8'h00 at cycle n+5 of an 8'hA5 frame.
  - Ignored; the original sequence completes unchanged.
  - Back-to-back Load in the Done cycle starts the next frame at the following cycle.
- **Reset mid-frame:** Reset asserted at cycle n+7.
  - Dout=1, Busy=0, Ready=1 immediately; no Done pulse.
  - After release, a new Load=8'h81 transmits correctly.
- **Macro undefined:** Data=8'hA5, Repeat=0.
  - Dout in cycles n+1..n+8 = 1,0,1,0,0,1,0,1.
  - Done in cycle n+9.
